// File: rtl/muxn_pkg.sv
// Shared constants for the registered N-to-1 selector (muxn_reg).
`timescale 1ns/100ps
package muxn_pkg;
  localparam logic MODE_FIX = 1'b0;
  localparam logic MODE_RR  = 1'b1;
  localparam int   STAT_W   = 16;
endpackage

// File: rtl/muxn_rr_pick.sv
// Combinational round-robin picker: first valid channel at or after i_ptr, wrapping at N.
`timescale 1ns/100ps
module muxn_rr_pick #(
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  i_dv,
  input  logic [SW-1:0] i_ptr,
  output logic          o_found,
  output logic [SW-1:0] o_idx
);
  int j;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    j       = 0;
    // Scan from the farthest offset down so the closest valid channel wins last.
    if (int'(i_ptr) < N) begin
      for (int k = N - 1; k >= 0; k--) begin
        j = int'(i_ptr) + k;
        if (j >= N) j = j - N;
        if (i_dv[j]) begin
          o_found = 1'b1;
          o_idx   = SW'(j);
        end
      end
    end
  end
endmodule

// File: rtl/muxn_reg.sv
// Registered, handshaked N-to-1 selector with fixed or round-robin channel choice.
// Optional output-transfer counter port CNT when MUXN_REG_STAT_EN is defined.
`timescale 1ns/100ps
module muxn_reg
  import muxn_pkg::*;
#(
  parameter  int W  = 8,
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              MODE,
  input  logic [SW-1:0]     SEL,
  input  logic [N*W-1:0]    D,
  input  logic [N-1:0]      DV,
  output logic [N-1:0]      DR,
  output logic [W-1:0]      Y,
  output logic              YV,
  input  logic              YR,
  output logic [SW-1:0]     YCH
`ifdef MUXN_REG_STAT_EN
  ,
  output logic [STAT_W-1:0] CNT
`endif
);
  logic [W-1:0]  r_y_p1;
  logic          r_vld_p1;
  logic [SW-1:0] r_ych_p1;
  logic [SW-1:0] r_ptr;

  logic          w_ld;
  logic          w_rr_found;
  logic [SW-1:0] w_rr_idx;
  logic          w_fix_found;
  logic          w_gnt;
  logic [SW-1:0] w_g;
  logic [W-1:0]  w_din;
  logic          w_in_xfer;
  logic          w_out_xfer;
  logic [SW-1:0] w_ptr_nxt;

  muxn_rr_pick #(.N(N)) u_pick (
    .i_dv    (DV),
    .i_ptr   (r_ptr),
    .o_found (w_rr_found),
    .o_idx   (w_rr_idx)
  );

  assign w_ld       = !r_vld_p1 || YR;
  assign w_out_xfer = r_vld_p1 && YR;

  // SEL values at or beyond N simply never match a channel.
  always_comb begin
    w_fix_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (SEL == SW'(i) && DV[i]) w_fix_found = 1'b1;
    end
  end

  assign w_gnt     = (MODE == MODE_RR) ? w_rr_found : w_fix_found;
  assign w_g       = (MODE == MODE_RR) ? w_rr_idx   : SEL;
  assign w_in_xfer = w_gnt && w_ld;
  assign w_ptr_nxt = (w_g == SW'(N - 1)) ? '0 : w_g + SW'(1);

  always_comb begin
    DR    = '0;
    w_din = '0;
    for (int i = 0; i < N; i++) begin
      if (w_g == SW'(i)) begin
        w_din = D[i*W +: W];
        if (w_gnt) DR[i] = w_ld;
      end
    end
  end

  // Stage p1: one-entry output register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_y_p1   <= '0;
      r_vld_p1 <= 1'b0;
      r_ych_p1 <= '0;
    end else if (w_in_xfer) begin
      r_y_p1   <= w_din;
      r_ych_p1 <= w_g;
      r_vld_p1 <= 1'b1;
    end else if (w_out_xfer) begin
      r_vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_ptr <= '0;
    end else if (w_in_xfer && MODE == MODE_RR) begin
      r_ptr <= w_ptr_nxt;
    end
  end

`ifdef MUXN_REG_STAT_EN
  logic [STAT_W-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_cnt <= '0;
    end else if (w_out_xfer) begin
      r_cnt <= r_cnt + STAT_W'(1);
    end
  end

  assign CNT = r_cnt;
`endif

  assign Y   = r_y_p1;
  assign YV  = r_vld_p1;
  assign YCH = r_ych_p1;
endmodule
